// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared constants and state encoding for the mux scan
//               sequencer. NLANES is the number of mux data lanes, ADDR_W is
//               the width of the mux address bus, and LANE_W is the width of
//               the internal lane counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam int NLANES = 8;
  localparam int ADDR_W = 4;
  localparam int LANE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/mux_scan_sequencer_lane_counter.sv
`default_nettype none
// ============================================================================
// Module      : lane_counter
// Description : 3-bit lane counter. It counts up, or down when DOWN = 1.
//               A load takes priority over a step.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset
//               load     - load load_val on the next edge
//               load_val - lane to load
//               step     - advance one lane in the configured direction
//               count    - current lane
//               terminal - count is the last lane of the walk
// Revision    : 1.0 - initial release
// ============================================================================
module lane_counter
  import mux_scan_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LANE_W-1:0] load_val,
  input  logic              step,
  output logic [LANE_W-1:0] count,
  output logic              terminal
);

  localparam logic [LANE_W-1:0] C_TERMINAL = DOWN ? '0 : '1;

  logic [LANE_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (step) begin
      // Wrap is harmless: the FSM leaves RUN on the terminal lane.
      r_count <= DOWN ? r_count - 1'b1 : r_count + 1'b1;
    end
  end

  assign count    = r_count;
  assign terminal = (r_count == C_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : This block captures a byte and presents it on the 8:1 mux
//               data inputs. It then walks the mux address across all lanes
//               and registers the returned mux output as a serial bit stream.
// Ports       : clk, rst  - clock and asynchronous active-high reset
//               start     - request to serialize data_in (IDLE/LAST only)
//               data_in   - byte to serialize
//               X, A, EN  - mux data, address and enable
//               q_in      - mux Q return (combinational)
//               bit_out   - registered serial bit
//               bit_valid - bit_out carries a stream bit
//               busy      - a byte is in flight
//               done      - coincides with the final bit_valid
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        data_in,
  output logic [7:0]        X,
  output logic [ADDR_W-1:0] A,
  output logic              EN,
  input  logic              q_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [LANE_W-1:0] C_FIRST_LANE = MSB_FIRST ? LANE_W'(NLANES - 1) : '0;

  scan_state_t       r_state;
  scan_state_t       w_next_state;
  logic              w_accept;
  logic [LANE_W-1:0] w_lane;
  logic              w_terminal;
  logic [7:0]        r_x;
  logic              r_bit_out;
  logic              r_bit_valid;

  // A new byte can start from IDLE, or from LAST to run bytes back-to-back.
  assign w_accept = start && ((r_state == IDLE) || (r_state == LAST));

  lane_counter #(
    .DOWN (MSB_FIRST)
  ) u_lane_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept),
    .load_val (C_FIRST_LANE),
    .step     (r_state == RUN),
    .count    (w_lane),
    .terminal (w_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    EN           = 1'b0;
    A            = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = RUN;
      end
      RUN: begin
        EN   = 1'b1;
        A    = {{(ADDR_W-LANE_W){1'b0}}, w_lane};
        busy = 1'b1;
        if (w_terminal) w_next_state = LAST;
      end
      LAST: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = start ? RUN : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Each RUN cycle registers the mux return for the lane that is presented
  // in that cycle. The stream therefore trails the address by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      if (w_accept) r_x <= data_in;
      r_bit_valid <= (r_state == RUN);
      if (r_state == RUN) r_bit_out <= q_in;
    end
  end

  assign X         = r_x;
  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;

endmodule
`default_nettype wire

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream control stage for the gate-level 8:1 multiplexer `meu_primeiro_mux8x1`. On a start request the block captures one byte and holds it on the mux data inputs. It then walks the mux select address across all eight lanes with enable asserted, registers the mux output each cycle, and emits the byte as a serial bit stream with a valid strobe and an end-of-byte done pulse.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 walks the address 0→7 (LSB first); 1 walks it 7→0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to serialize `data_in`; sampled only when accepted, see Operation.
- `data_in`  in  8  byte to serialize; captured on the accepting edge.
- `X`  out  8  captured byte; drives the mux `X`.
- `A`  out  4  lane address; drives the mux `A`; `A[3]` is constant 0.
- `EN`  out  1  mux enable; drives the mux `EN`.
- `q_in`  in  1  mux `Q` return, combinational from `X`/`A`/`EN`.
- `bit_out`  out  1  registered serial bit.
- `bit_valid`  out  1  `bit_out` holds a stream bit this cycle.
- `busy`  out  1  a byte is in flight.
- `done`  out  1  one-cycle pulse coincident with the final `bit_valid`.

## Operation
- States: IDLE, RUN, LAST.
- IDLE: `EN`=0, `A`=0, `busy`=0.
  - `start`=1 captures `data_in` into `X`, loads the lane counter with the first lane (0, or 7 when `MSB_FIRST`), and moves to RUN.
- RUN: `EN`=1, `A`={1'b0, lane}, `busy`=1.
  - Each cycle `bit_out`<=`q_in` and `bit_valid`<=1, so the output is the bit for the lane presented in the previous cycle.
  - The lane counter steps +1 (or −1 when `MSB_FIRST`).
  - After the eighth lane (7, or 0 when `MSB_FIRST`), move to LAST.
- LAST: `EN`=0, `A`=0, `busy`=1.
  - Final bit is visible with `bit_valid`=1 and `done`=1.
  - `start`=1 here is accepted exactly as in IDLE: capture the byte and go to RUN, giving back-to-back bytes. Otherwise go to IDLE.
- `start` in RUN is ignored: no capture, and `X` is unchanged.
- `X` holds its value outside the capture edge. It is not cleared on return to IDLE.
- `bit_valid` is 0 in every cycle other than the eight stream cycles. `bit_out` holds its last value when not valid.
- Reset is asynchronous and may occur mid-byte. All outputs go to 0 immediately, the state goes to IDLE, and the partial byte is discarded with no `done`.
- Lane counter arithmetic is 3-bit unsigned. Wrap-around never occurs in normal flow because the terminal lane forces the exit from RUN.

## Timing
- Reset values: `X`=0, `A`=0, `EN`=0, `bit_out`=0, `bit_valid`=0, `busy`=0, `done`=0, state IDLE.
- `start` accepted at edge 0 gives:
  - RUN during cycles 1–8, with `A` = lane sequence.
  - `bit_valid` in cycles 2–9.
  - `done` and LAST in cycle 9.
  - `busy` in cycles 1–9.
- Latency from the accepting edge to the first valid bit is 2 cycles. The last valid bit arrives at cycle 9.
- Back-to-back throughput is 9 cycles per byte: a `start` held in LAST gives RUN again at cycle 10.
- `q_in` is used combinationally within the same cycle. The mux path must meet one clock period.

## Structure
- Package `mux_scan_pkg` holds:
  - `NLANES`=8, `ADDR_W`=4, `LANE_W`=3.
  - the `scan_state_t` enum {IDLE, RUN, LAST}.
- Sub-module `lane_counter`: a 3-bit up/down counter with a load value, a load enable, a step enable and a terminal-lane flag, parameterized by direction.
- The top level holds the FSM, the `X` capture register and the output register. The bench instantiates the sequencer with `meu_primeiro_mux8x1` closing the `X`/`A`/`EN`→`q_in` loop.

## Test plan
- Reset check: assert `rst` mid-simulation → all outputs 0 asynchronously, before the next edge.
- Basic serialization: `MSB_FIRST`=0, `data_in`=0xA5, one-cycle `start` → `A` sequence 0..7, `bit_out` stream 1,0,1,0,0,1,0,1 in cycles 2–9, `done` at cycle 9 only.
- Reversed order: `MSB_FIRST`=1, `data_in`=0x3C → `A` sequence 7..0, stream 0,0,1,1,1,1,0,0.
- Late input change and start while busy: change `data_in` to 0xFF and pulse `start` during RUN → `X` stays 0xA5, stream is unchanged, no extra byte.
- Back-to-back bytes: hold `start` with 0x01 then 0x80 → second RUN begins at cycle 10, streams are 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1, two `done` pulses 9 cycles apart.
- Reset mid-operation: `rst` at cycle 5 → `EN`/`bit_valid`/`busy` drop at once, no `done`, a new `start` after release produces a full correct byte.
